// File: rtl/exe_issue_scheduler.sv
// Issue scheduler for the multi-latency exe stage: writeback reservation table plus pending-rd hazard check.
// Optional stall counters are built when SCHED_PERF_EN is defined.

module exe_sched_slot_chk (
  input  logic       vld,
  input  logic       we,
  input  logic [4:0] rd,
  input  logic       rs1_used,
  input  logic [4:0] rs1,
  input  logic       rs2_used,
  input  logic [4:0] rs2,
  input  logic       iss_we,
  input  logic [4:0] iss_rd,
  output logic       hz
);
  // x0 is filtered on the pending side, so a source or dest of x0 never matches
  assign hz = vld & we & (rd != 5'd0) &
              ((rs1_used & (rs1 == rd)) | (rs2_used & (rs2 == rd)) | (iss_we & (iss_rd == rd)));
endmodule

module exe_issue_scheduler #(
  parameter int MAX_EXE_STAGES = 4,
  parameter int LAT_W          = $clog2(MAX_EXE_STAGES+1),
  parameter int CNT_W          = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             issue_valid_i,
  output logic             issue_ready_o,
  input  logic [LAT_W-1:0] issue_lat_i,
  input  logic             issue_we_i,
  input  logic [4:0]       issue_rd_i,
  input  logic             issue_rs1_used_i,
  input  logic [4:0]       issue_rs1_i,
  input  logic             issue_rs2_used_i,
  input  logic [4:0]       issue_rs2_i,
  output logic             stall_struct_o,
  output logic             stall_raw_o,
  output logic             wb_valid_o,
  output logic             wb_we_o,
  output logic [4:0]       wb_rd_o,
  output logic             busy_o
`ifdef SCHED_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_struct_cnt_o,
  output logic [CNT_W-1:0] stall_raw_cnt_o
`endif
);
  localparam int S = MAX_EXE_STAGES;

  // Index k holds the entry retiring k cycles from now; index 0 is the retiring (wb) entry.
  logic [S:0]      vld_pipe;
  logic [S:0]      we_pipe;
  logic [S:0][4:0] rd_pipe;

  logic [LAT_W-1:0] lat_eff;
  logic [S:0]       hz;
  logic [S:1]       ins;
  logic             slot_busy;
  logic             raw_hit;
  logic             fire;

  always_comb begin
    lat_eff = issue_lat_i;
    if (issue_lat_i == '0)
      lat_eff = LAT_W'(1);
    else if (issue_lat_i > LAT_W'(S))
      lat_eff = LAT_W'(S);
  end

  for (genvar k = 0; k <= S; k++) begin : g_slot
    exe_sched_slot_chk u_chk (
      .vld      (vld_pipe[k]),
      .we       (we_pipe[k]),
      .rd       (rd_pipe[k]),
      .rs1_used (issue_rs1_used_i),
      .rs1      (issue_rs1_i),
      .rs2_used (issue_rs2_used_i),
      .rs2      (issue_rs2_i),
      .iss_we   (issue_we_i),
      .iss_rd   (issue_rd_i),
      .hz       (hz[k])
    );
  end

  assign slot_busy      = vld_pipe[lat_eff];
  assign raw_hit        = |hz;
  assign issue_ready_o  = ~(slot_busy | raw_hit);
  assign stall_struct_o = issue_valid_i & slot_busy;
  assign stall_raw_o    = issue_valid_i & raw_hit;
  assign fire           = issue_valid_i & issue_ready_o;

  always_comb begin
    ins = '0;
    for (int k = 1; k <= S; k++)
      ins[k] = fire && (lat_eff == LAT_W'(k));
  end

  // New entry lands one below its latency slot because the whole table shifts this edge;
  // fire is only possible when that slot is empty, so the merge never collides.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_pipe <= '0;
      we_pipe  <= '0;
      rd_pipe  <= '0;
    end else begin
      for (int k = 0; k < S; k++) begin
        vld_pipe[k] <= vld_pipe[k+1] | ins[k+1];
        we_pipe[k]  <= ins[k+1] ? issue_we_i : we_pipe[k+1];
        rd_pipe[k]  <= ins[k+1] ? issue_rd_i : rd_pipe[k+1];
      end
      vld_pipe[S] <= 1'b0;
      we_pipe[S]  <= 1'b0;
      rd_pipe[S]  <= 5'd0;
    end
  end

  assign wb_valid_o = vld_pipe[0];
  assign wb_we_o    = we_pipe[0];
  assign wb_rd_o    = rd_pipe[0];
  assign busy_o     = |vld_pipe;

`ifdef SCHED_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_struct_cnt_o <= '0;
      stall_raw_cnt_o    <= '0;
    end else begin
      if (stall_struct_o && (stall_struct_cnt_o != '1))
        stall_struct_cnt_o <= stall_struct_cnt_o + 1'b1;
      if (stall_raw_o && (stall_raw_cnt_o != '1))
        stall_raw_cnt_o <= stall_raw_cnt_o + 1'b1;
    end
  end
`endif

endmodule
